// File: rtl/shared_timer_arbiter_if.sv
// Bus bundle between the requesters and the shared cycle timer.
interface shared_timer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CW      = 28,
  parameter int IW      = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*CW-1:0] cycles_in;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;
  logic [IW-1:0]         owner;
  logic [CW-1:0]         count;

  // Requester side: raises requests and supplies counts, watches grant/done.
  modport master (
    output req, cycles_in,
    input  grant, done, busy, owner, count
  );

  // Timer side: arbitrates requests and reports ownership and expiry.
  modport slave (
    input  req, cycles_in,
    output grant, done, busy, owner, count
  );
endinterface

// File: rtl/shared_timer_arbiter.sv
// One cycle-count timer shared round-robin among NUM_REQ requesters.
// The winner's count is latched at grant; the timer runs target+1 cycles,
// then pulses done to the owner for one cycle and returns to idle.
module shared_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CW      = 28,
  parameter int IW      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  shared_timer_arbiter_if.slave  tmr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] target_q, target_d;

  logic [CW-1:0] slice_w [NUM_REQ];
  logic [IW:0]   scan_idx;
  logic [IW-1:0] win_idx;
  logic          win_vld;

  // Unpack the flat count bus into one entry per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slice_w[i] = tmr.cycles_in[i*CW +: CW];
    end
  end

  // Round-robin pick: first set request after the last owner, wrapping.
  always_comb begin
    scan_idx = '0;
    win_idx  = '0;
    win_vld  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = {1'b0, last_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IW+1)'(NUM_REQ);
      end
      if (!win_vld && tmr.req[scan_idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan_idx[IW-1:0];
      end
    end
  end

  // Control state register; reset interrupts any run without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Latched target count; only meaningful while a run is active.
  always_ff @(posedge clock) begin
    target_q <= target_d;
  end

  // Next-state and counter update; abort beats expiry in the same cycle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    count_d  = count_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (win_vld) begin
          owner_d  = win_idx;
          target_d = slice_w[win_idx];
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!tmr.req[owner_q]) begin
          last_d  = owner_q;
          count_d = '0;
          state_d = ST_IDLE;
        end else if (count_q == target_q) begin
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        count_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode outputs: grant during RUN, done pulse during DONE, busy for both.
  always_comb begin
    tmr.grant = '0;
    tmr.done  = '0;
    tmr.busy  = 1'b0;
    tmr.owner = owner_q;
    tmr.count = count_q;
    case (state_q)
      ST_RUN: begin
        tmr.grant = NUM_REQ'(1) << owner_q;
        tmr.busy  = 1'b1;
      end
      ST_DONE: begin
        tmr.done = NUM_REQ'(1) << owner_q;
        tmr.busy = 1'b1;
      end
      default: begin
        tmr.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Directed bench for shared_timer_arbiter: a CW=28 build for arbitration,
// abort and reset, and a CW=4 build for the full-range count.
module tb_shared_timer_arbiter;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  shared_timer_arbiter_if #(.NUM_REQ(4), .CW(28), .IW(2)) ifa ();
  shared_timer_arbiter_if #(.NUM_REQ(4), .CW(4),  .IW(2)) ifb ();

  shared_timer_arbiter #(.NUM_REQ(4), .CW(28), .IW(2)) dut_a (
    .clock (clock),
    .reset (reset),
    .tmr   (ifa)
  );

  shared_timer_arbiter #(.NUM_REQ(4), .CW(4), .IW(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .tmr   (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cyc_a(input int i, input int v);
    ifa.cycles_in[i*28 +: 28] = 28'(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] eg;
    logic [3:0] ed;
    int p;
    int w;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    ifa.req = '0;
    ifa.cycles_in = '0;
    ifb.req = '0;
    ifb.cycles_in = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_grant", 32'(ifa.grant), 32'h0);
    chk("rst_done",  32'(ifa.done),  32'h0);
    chk("rst_busy",  32'(ifa.busy),  32'h0);
    chk("rst_count", 32'(ifa.count), 32'h0);
    chk("rst_owner", 32'(ifa.owner), 32'h0);
    reset = 1'b0;
    tick();

    // Single request, count 5; a later change of cycles_in is ignored
    set_cyc_a(0, 5);
    ifa.req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("single_grant_c%0d", c), 32'(ifa.grant), (c <= 6) ? 32'h1 : 32'h0);
      chk($sformatf("single_done_c%0d", c),  32'(ifa.done),  (c == 7) ? 32'h1 : 32'h0);
      chk($sformatf("single_busy_c%0d", c),  32'(ifa.busy),  (c <= 7) ? 32'h1 : 32'h0);
      if (c == 2) set_cyc_a(0, 1);
      if (c == 7) begin
        chk("single_count_done", 32'(ifa.count), 32'd5);
        ifa.req = 4'b0000;
      end
    end
    chk("single_count_idle", 32'(ifa.count), 32'd0);

    // Zero count on requester 2
    set_cyc_a(2, 0);
    ifa.req = 4'b0100;
    tick();
    chk("zero_grant", 32'(ifa.grant), 32'h4);
    chk("zero_owner", 32'(ifa.owner), 32'd2);
    tick();
    chk("zero_grant2", 32'(ifa.grant), 32'h0);
    chk("zero_done",   32'(ifa.done),  32'h4);
    ifa.req = 4'b0000;
    tick();
    chk("zero_idle_busy",  32'(ifa.busy),  32'h0);
    chk("zero_idle_done",  32'(ifa.done),  32'h0);
    chk("zero_idle_owner", 32'(ifa.owner), 32'd2);

    // Round-robin after a fresh reset: 3 grant + 1 done + 1 idle per winner
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_cyc_a(i, 2);
    ifa.req = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      tick();
      p  = (c - 1) % 5;
      w  = ((c - 1) / 5) % 4;
      eg = (p < 3)  ? (4'b0001 << w) : 4'b0000;
      ed = (p == 3) ? (4'b0001 << w) : 4'b0000;
      chk($sformatf("rr_grant_c%0d", c), 32'(ifa.grant), 32'(eg));
      chk($sformatf("rr_done_c%0d", c),  32'(ifa.done),  32'(ed));
      if (c == 25) ifa.req = 4'b0000;
    end
    tick();
    chk("rr_end_busy", 32'(ifa.busy), 32'h0);

    // Abort: requester 1 (count 10) drops req in cycle 4, pending 3 follows
    set_cyc_a(1, 10);
    set_cyc_a(3, 1);
    ifa.req = 4'b1010;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("abort_done_c%0d", c), 32'(ifa.done), 32'h0);
      if (c <= 4) chk($sformatf("abort_grant_c%0d", c), 32'(ifa.grant), 32'h2);
      if (c == 4) ifa.req = 4'b1000;
      if (c == 5) begin
        chk("abort_idle_grant", 32'(ifa.grant), 32'h0);
        chk("abort_idle_busy",  32'(ifa.busy),  32'h0);
        chk("abort_idle_count", 32'(ifa.count), 32'h0);
      end
    end
    chk("abort_next_grant", 32'(ifa.grant), 32'h8);
    chk("abort_next_owner", 32'(ifa.owner), 32'd3);
    ifa.req = 4'b0000;
    tick();
    chk("abort3_idle_busy", 32'(ifa.busy), 32'h0);
    chk("abort3_no_done",   32'(ifa.done), 32'h0);

    // Reset mid-RUN: owner 2 at count 3 of 20
    set_cyc_a(2, 20);
    ifa.req = 4'b0100;
    for (int c = 1; c <= 4; c++) tick();
    chk("mid_owner", 32'(ifa.owner), 32'd2);
    chk("mid_count", 32'(ifa.count), 32'd3);
    reset = 1'b1;
    ifa.req = 4'b0101;
    tick();
    chk("mid_rst_grant", 32'(ifa.grant), 32'h0);
    chk("mid_rst_done",  32'(ifa.done),  32'h0);
    chk("mid_rst_busy",  32'(ifa.busy),  32'h0);
    chk("mid_rst_count", 32'(ifa.count), 32'h0);
    chk("mid_rst_owner", 32'(ifa.owner), 32'h0);
    reset = 1'b0;
    tick();
    chk("mid_after_grant", 32'(ifa.grant), 32'h1);
    chk("mid_after_owner", 32'(ifa.owner), 32'd0);
    ifa.req = 4'b0000;
    tick();
    chk("mid_abort_busy", 32'(ifa.busy), 32'h0);

    // Full-range count on the CW=4 build: 16 RUN cycles, done in cycle 17
    ifb.cycles_in[3:0] = 4'd15;
    ifb.req = 4'b0001;
    for (int c = 1; c <= 18; c++) begin
      tick();
      chk($sformatf("max_grant_c%0d", c), 32'(ifb.grant), (c <= 16) ? 32'h1 : 32'h0);
      chk($sformatf("max_done_c%0d", c),  32'(ifb.done),  (c == 17) ? 32'h1 : 32'h0);
      chk($sformatf("max_count_c%0d", c), 32'(ifb.count),
          (c <= 16) ? 32'(c - 1) : ((c == 17) ? 32'd15 : 32'd0));
      if (c == 17) ifb.req = 4'b0000;
    end
    chk("max_idle_busy", 32'(ifb.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
